// File: rtl/accu_pkg.sv
// Shared helpers for the streaming accumulator: derived widths, sample
// extension and the group-length clamp rule.
package accu_pkg;

    localparam int unsigned EXT_W = 64;

    function automatic int unsigned cnt_width(input int unsigned max_n);
        return unsigned'($clog2(max_n + 1));
    endfunction

    function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned max_n);
        return data_w + unsigned'($clog2(max_n));
    endfunction

    // Left-align the sample, then shift back so the top bits fill with sign or zero.
    function automatic logic [EXT_W-1:0] ext_sample(input logic [EXT_W-1:0] data,
                                                    input int unsigned     data_w,
                                                    input logic            signed_mode);
        logic [EXT_W-1:0] r;
        r = data << (EXT_W - data_w);
        if (signed_mode) begin
            r = $unsigned($signed(r) >>> (EXT_W - data_w));
        end else begin
            r = r >> (EXT_W - data_w);
        end
        return r;
    endfunction

    function automatic int unsigned eff_len(input logic [31:0] cfg, input int unsigned max_n);
        if (cfg == 32'd0) begin
            return 1;
        end else if (cfg > max_n) begin
            return max_n;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/accu_grp_ctr.sv
// Group sample counter: latches the effective group length on the first
// sample and flags the accept that closes the group.
module accu_grp_ctr
    import accu_pkg::*;
#(
    parameter  int unsigned MAX_N = 16,
    localparam int unsigned CNT_W = cnt_width(MAX_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             in_last,
    input  logic [CNT_W-1:0] cfg_len,
    output logic [CNT_W-1:0] count,
    output logic             first,
    output logic             close
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_c;
    logic [CNT_W-1:0] next_cnt_c;

    // On the first sample the freshly clamped cfg_len applies, so len=1 closes at once.
    always_comb begin
        len_c      = first ? CNT_W'(eff_len(32'(cfg_len), MAX_N)) : len_q;
        next_cnt_c = count_q + CNT_W'(1);
    end

    assign count = count_q;
    assign first = (count_q == '0);
    assign close = accept && ((next_cnt_c == len_c) || in_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            len_q   <= '0;
        end else if (accept) begin
            if (first) begin
                len_q <= len_c;
            end
            count_q <= close ? '0 : next_cnt_c;
        end
    end

endmodule

// File: rtl/accu_stream.sv
// Streaming group accumulator with valid/ready on both sides; one registered
// sum per group, held until the downstream takes it.
module accu_stream
    import accu_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned MAX_N  = 16,
    parameter  int unsigned SIGNED = 0,
    localparam int unsigned CNT_W  = cnt_width(MAX_N),
    localparam int unsigned OUT_W  = sum_width(DATA_W, MAX_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt
);

    logic             accept_c;
    logic             grp_first;
    logic             grp_close;
    logic [CNT_W-1:0] grp_count;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] ext_c;
    logic [OUT_W-1:0] sum_c;

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    accu_grp_ctr #(
        .MAX_N (MAX_N)
    ) u_grp_ctr (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept_c),
        .in_last (in_last),
        .cfg_len (cfg_len),
        .count   (grp_count),
        .first   (grp_first),
        .close   (grp_close)
    );

    // Running sum including the sample being accepted this cycle.
    always_comb begin
        ext_c = OUT_W'(ext_sample(EXT_W'(in_data), DATA_W, (SIGNED != 0)));
        sum_c = grp_first ? ext_c : (acc_q + ext_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
        end else begin
            if (accept_c) begin
                acc_q <= sum_c;
            end
            // A close can only happen when the previous sum is free or being taken.
            if (grp_close) begin
                out_valid <= 1'b1;
                out_sum   <= sum_c;
                out_cnt   <= grp_count + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accu_stream.sv
// Scoreboard bench for accu_stream: an unsigned and a signed instance share the
// stimulus; a group-level reference model predicts every emitted sum.
module tb_accu_stream;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAX_N  = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OUT_W  = 12;

    typedef struct {
        logic [OUT_W-1:0] sum_u;
        logic [OUT_W-1:0] sum_s;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  cfg_len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b1;

    logic              u_in_ready, u_out_valid;
    logic [OUT_W-1:0]  u_out_sum;
    logic [CNT_W-1:0]  u_out_cnt;
    logic              s_in_ready, s_out_valid;
    logic [OUT_W-1:0]  s_out_sum;
    logic [CNT_W-1:0]  s_out_cnt;

    exp_t              sb[$];
    logic [DATA_W-1:0] grp[$];
    int unsigned       grp_len = 1;
    int                su;
    int                ss;
    bit                just_closed = 1'b0;
    bit                chk_rst = 1'b0;
    bit                rand_rdy = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    accu_stream #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
        .out_sum(u_out_sum), .out_cnt(u_out_cnt)
    );

    accu_stream #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_cnt(s_out_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor and reference model, both sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            grp.delete();
            sb.delete();
            just_closed = 1'b0;
            chk_rst     = 1'b1;
        end else begin
            if (chk_rst) begin
                chk("rst_out_valid", 32'(u_out_valid), 32'd0);
                chk("rst_out_sum",   32'(u_out_sum),   32'd0);
                chk("rst_out_cnt",   32'(u_out_cnt),   32'd0);
                chk("rst_in_ready",  32'(u_in_ready),  32'd1);
                chk("rst_s_out_sum", 32'(s_out_sum),   32'd0);
                chk_rst = 1'b0;
            end
            chk("in_ready_rule", 32'(u_in_ready), 32'(!u_out_valid || out_ready));
            chk("signed_handshake", 32'({s_in_ready, s_out_valid}), 32'({u_in_ready, u_out_valid}));
            if (just_closed) begin
                chk("latency_valid", 32'(u_out_valid), 32'd1);
            end
            if (u_out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(u_out_valid), 32'd0);
                end else begin
                    chk("sum_unsigned", 32'(u_out_sum), 32'(sb[0].sum_u));
                    chk("sum_signed",   32'(s_out_sum), 32'(sb[0].sum_s));
                    chk("cnt_unsigned", 32'(u_out_cnt), 32'(sb[0].cnt));
                    chk("cnt_signed",   32'(s_out_cnt), 32'(sb[0].cnt));
                    if (out_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end
            just_closed = 1'b0;
            if (in_valid && u_in_ready) begin
                if (grp.size() == 0) begin
                    grp_len = (cfg_len == 0) ? 1 : ((cfg_len > MAX_N) ? MAX_N : int'(cfg_len));
                end
                grp.push_back(in_data);
                if (grp.size() == int'(grp_len) || in_last) begin
                    su = 0;
                    ss = 0;
                    foreach (grp[i]) begin
                        su += int'(grp[i]);
                        ss += int'($signed(grp[i]));
                    end
                    sb.push_back('{sum_u: OUT_W'(su), sum_s: OUT_W'(ss), cnt: CNT_W'(grp.size())});
                    grp.delete();
                    just_closed = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        int  budget;
        bit  got;
        budget   = 0;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            got = u_in_ready;
            tick();
            budget++;
        end while (!got && budget < 200);
        if (!got) begin
            chk("send_timeout", 32'(got), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        cfg_len = 5'd4;
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
        idle(3);

        cfg_len = 5'd16;
        repeat (16) send(8'd255, 1'b0);
        idle(3);

        cfg_len = 5'd8;
        send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b1);
        repeat (8) send(8'd1, 1'b0);
        idle(3);

        // Held output blocks the next sample until the sum is taken.
        cfg_len   = 5'd2;
        out_ready = 1'b0;
        send(8'd3, 1'b0); send(8'd4, 1'b0);
        fork
            send(8'd9, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(u_in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        send(8'd1, 1'b0);
        idle(3);

        cfg_len = 5'd1;
        send(8'hFD, 1'b0); send(8'h05, 1'b0); send(8'h80, 1'b0);
        cfg_len = 5'd0;
        send(8'hFD, 1'b0); send(8'h05, 1'b0); send(8'h80, 1'b0);
        idle(3);

        cfg_len = 5'd4;
        send(8'd10, 1'b0); send(8'd20, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'd1, 1'b0); send(8'd2, 1'b0);
        cfg_len = 5'd2;
        send(8'd3, 1'b0); send(8'd4, 1'b0);
        idle(3);

        rand_rdy = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) cfg_len = CNT_W'($urandom_range(0, 20));
            send(DATA_W'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
